// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed 8-digit hex seven-segment driver. A new
//               value is captured on load and shown only from the next frame
//               boundary, so every scan shows one consistent value.
//               Optional build macro SEG7_LZ_BLANK_EN adds leading-zero
//               suppression (digit 0 always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int DIGITS  = 8
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int               IDX_W    = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_q, pend_d;
  logic             pending_q, pending_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             fd_q, fd_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic             blank;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);
  assign nibble   = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero
  logic [7:0] lz;
  assign lz[0] = 1'b0;
  for (genvar gi = 1; gi < 8; gi++) begin : g_lz
    assign lz[gi] = ~|disp_q[31:4*gi];
  end
  assign blank = blank_mask[idx_q] | lz[idx_q];
`else
  assign blank = blank_mask[idx_q];
`endif

  // Scan divider, digit index and frame-synchronised capture of new data
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    idx_d     = tick ? idx_q + 1'b1 : idx_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (boundary) begin
      // A load coinciding with the boundary supersedes anything pending
      if (load) begin
        disp_d = data_in;
      end else if (pending_q) begin
        disp_d = pend_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pend_d    = data_in;
      pending_d = 1'b1;
    end
  end

  // Pin drive for the digit currently selected; masks are used live
  always_comb begin
    an_d  = ~(8'h01 << idx_q);
    seg_d = {~dp_mask[idx_q], hex7(nibble)};
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
    fd_d = boundary;
  end

  // All state, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RST) begin
      div_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= 8'hFF;
      an_q      <= 8'hFF;
      fd_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver (CLK_DIV=4). Stimulus
//               pushes whole expected frames; a monitor pops one on each
//               frame_done and compares every digit slot of the next frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  blank_mask;
  logic [7:0]  dp_mask;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        frame_done;

  typedef struct packed {
    logic [63:0] an;
    logic [63:0] seg;
  } frame_t;

  frame_t exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     fnum  = 0;

  seg7_scan_driver #(.CLK_DIV(CLK_DIV), .DIGITS(8)) dut (
    .clk        (clk),
    .RST        (RST),
    .data_in    (data_in),
    .load       (load),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .SEG        (SEG),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected frame: segs holds digit i at [8i+:8]; blanked digits drive FF/FF
  function automatic frame_t mk(input logic [63:0] segs, input logic [7:0] blnk);
    frame_t     f;
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m = 8'h01 << i;
      f.an[8*i+:8]  = blnk[i] ? 8'hFF : ~m;
      f.seg[8*i+:8] = blnk[i] ? 8'hFF : segs[8*i+:8];
    end
    return f;
  endfunction

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    if (frame_done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_frame: frame_done not seen after %0d cycles", n);
    end
  endtask

  task automatic pulse_load(input logic [31:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Monitor: digit 0 of the new frame appears one cycle after frame_done
  initial begin : monitor
    frame_t f;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1 && exp_q.size() > 0) begin
        f = exp_q.pop_front();
        @(negedge clk);
        for (int s = 0; s < 8; s++) begin
          if (s > 0) repeat (CLK_DIV) @(negedge clk);
          check($sformatf("frame%0d_AN%0d", fnum, s), AN, f.an[8*s+:8]);
          check($sformatf("frame%0d_SEG%0d", fnum, s), SEG, f.seg[8*s+:8]);
        end
        fnum++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int period;
    RST        = 1'b0;
    load       = 1'b0;
    data_in    = '0;
    blank_mask = '0;
    dp_mask    = '0;

    // Reset state, then the first slot shows digit 0 of a zero value
    repeat (3) @(negedge clk);
    check("reset_SEG", SEG, 8'hFF);
    check("reset_AN", AN, 8'hFF);
    check("reset_frame_done", {7'b0, frame_done}, 8'h00);
    exp_q.push_back(mk({8{8'hC0}}, 8'h00));
    RST = 1'b1;
    @(negedge clk);
    check("first_AN", AN, 8'hFE);
    check("first_SEG", SEG, 8'hC0);

    // Mid-frame load: current (monitored) frame stays all zero
    wait_frame();
    repeat (10) @(negedge clk);
    pulse_load(32'h0123_ABCD);
    exp_q.push_back(mk(64'hC0F9_A4B0_8883_C6A1, 8'h00));

    // Two loads in one frame: last one wins
    wait_frame();
    repeat (5) @(negedge clk);
    pulse_load(32'h1111_1111);
    repeat (5) @(negedge clk);
    pulse_load(32'h2222_2222);
    exp_q.push_back(mk({8{8'hA4}}, 8'h00));

    // Load exactly on the boundary cycle discards the older pending value
    wait_frame();
    repeat (5) @(negedge clk);
    exp_q.push_back(mk({8{8'h8E}}, 8'h00));
    exp_q.push_back(mk({8{8'h8E}}, 8'h00));
    pulse_load(32'h3333_3333);
    repeat (25) @(negedge clk);
    pulse_load(32'hFFFF_FFFF);
    wait_frame();
    wait_frame();

    // Blank upper digits, decimal point on digit 0
    wait_frame();
    repeat (5) @(negedge clk);
    blank_mask = 8'hF0;
    dp_mask    = 8'h01;
    exp_q.push_back(mk({{7{8'h8E}}, 8'h0E}, 8'hF0));
    wait_frame();
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (frame_done !== 1'b1 && period < 100);
    check("frame_period", 8'(period), 8'd32);
    @(negedge clk);
    check("frame_done_width", {7'b0, frame_done}, 8'h00);

    // Leading zeros: suppressed only in the SEG7_LZ_BLANK_EN build
    blank_mask = 8'h00;
    dp_mask    = 8'h00;
    pulse_load(32'h0000_00A5);
`ifdef SEG7_LZ_BLANK_EN
    exp_q.push_back(mk(64'hFFFF_FFFF_FFFF_8892, 8'hFC));
`else
    exp_q.push_back(mk(64'hC0C0_C0C0_C0C0_8892, 8'h00));
`endif
    wait_frame();
    repeat (3) @(negedge clk);
    pulse_load(32'h0000_0005);
`ifdef SEG7_LZ_BLANK_EN
    exp_q.push_back(mk(64'hFFFF_FFFF_FFFF_FF92, 8'hFE));
`else
    exp_q.push_back(mk(64'hC0C0_C0C0_C0C0_C092, 8'h00));
`endif
    wait_frame();
    repeat (30) @(negedge clk);

    // Reset mid-frame: scan restarts at digit 0 and pending data is lost
    pulse_load(32'h7777_7777);
    RST = 1'b0;
    @(negedge clk);
    check("midreset_SEG", SEG, 8'hFF);
    check("midreset_AN", AN, 8'hFF);
    RST = 1'b1;
    @(negedge clk);
    check("restart_AN", AN, 8'hFE);
    check("restart_SEG", SEG, 8'hC0);
    exp_q.push_back(mk({8{8'hC0}}, 8'h00));
    wait_frame();
    repeat (40) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
